branch_ctrl: RTL and testbench

Control-flow resolver that drives the instruction-fetch PC unit. Each cycle it takes decoded control fields of the instruction at the current PC plus a registered ALU flag set. It produces the fetch unit's branch command: Branch, PCSrc, RItype, CondTarget, Target and Halt. It also owns the run/halt state machine, the Done handshake to the testbench, and a taken-branch counter. It sits between the decoder/ALU and the fetch stage, and mirrors the fetch unit's command inputs.

---
 rtl/branch_pkg.sv | 35 +++
 rtl/branch_ctrl_if.sv | 46 ++++
 rtl/branch_lut.sv | 11 +
 rtl/branch_ctrl.sv | 100 ++++++++++
 tb/tb_branch_ctrl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch controller: FSM states, condition
// selects, flag bundle and the absolute-target lookup table contents.
package branch_pkg;

  localparam int D         = 12;
  localparam int LUT_AW    = 5;
  localparam int LUT_DEPTH = 1 << LUT_AW;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_N      = 2'b11;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
  } flags_t;

  // Jump targets; entry 5 is the program's main loop entry.
  localparam logic [D-1:0] LUT_ROM [LUT_DEPTH] = '{
    12'h000, 12'h010, 12'h020, 12'h030, 12'h040, 12'h02A, 12'h060, 12'h070,
    12'h080, 12'h090, 12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0, 12'h0E0, 12'h0F0,
    12'h100, 12'h110, 12'h120, 12'h130, 12'h140, 12'h150, 12'h160, 12'h170,
    12'h180, 12'h190, 12'h1A0, 12'h1B0, 12'h1C0, 12'h1D0, 12'h1E0, 12'h1F0
  };

endpackage

// File: rtl/branch_ctrl_if.sv
// Decoder/ALU-facing bundle of the branch controller: decoded control fields
// in, fetch-unit branch command plus Done/TakenCnt out.
interface branch_ctrl_if;
  import branch_pkg::*;

  logic              Init;
  logic              IsBranch;
  logic              IsJump;
  logic              IsHalt;
  logic [1:0]        CondSel;
  logic              CondInv;
  logic [2:0]        CondOff;
  logic [LUT_AW-1:0] LutIdx;
  logic              FlagWe;
  logic              ZeroIn;
  logic              CarryIn;
  logic              NegIn;

  // Command contract: the fetch command is combinational and valid in the
  // same cycle the instruction is presented; the fetch unit samples it at the
  // next rising edge. There is no ready back-pressure. Done is a level.
  logic              Branch;
  logic              PCSrc;
  logic              RItype;
  logic [2:0]        CondTarget;
  logic [D-1:0]      Target;
  logic              Halt;
  logic              Done;
  logic [CNT_W-1:0]  TakenCnt;
  state_t            state_dbg;

  modport master (
    output Init, IsBranch, IsJump, IsHalt, CondSel, CondInv, CondOff, LutIdx,
           FlagWe, ZeroIn, CarryIn, NegIn,
    input  Branch, PCSrc, RItype, CondTarget, Target, Halt, Done, TakenCnt,
           state_dbg
  );

  modport slave (
    input  Init, IsBranch, IsJump, IsHalt, CondSel, CondInv, CondOff, LutIdx,
           FlagWe, ZeroIn, CarryIn, NegIn,
    output Branch, PCSrc, RItype, CondTarget, Target, Halt, Done, TakenCnt,
           state_dbg
  );

endinterface

// File: rtl/branch_lut.sv
// Combinational ROM of absolute jump targets indexed by the decoded LUT index.
module branch_lut
  import branch_pkg::*;
(
  input  logic [LUT_AW-1:0] idx,
  output logic [D-1:0]      target
);

  assign target = LUT_ROM[idx];

endmodule

// File: rtl/branch_ctrl.sv
// Control-flow resolver: run/halt FSM, registered ALU flags, condition mux and
// saturating taken-branch counter feeding the fetch unit's command inputs.
module branch_ctrl
  import branch_pkg::*;
(
  input logic          CLK,
  input logic          reset,
  branch_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  flags_t           flags_q, flags_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic branch, pcsrc, ritype, halt;
  logic flag_sel, cond;

  branch_lut u_lut (
    .idx    (bus.LutIdx),
    .target (bus.Target)
  );

  always_comb begin
    flag_sel = 1'b1;
    case (bus.CondSel)
      COND_Z:  flag_sel = flags_q.z;
      COND_C:  flag_sel = flags_q.c;
      COND_N:  flag_sel = flags_q.n;
      default: flag_sel = 1'b1;
    endcase
    cond = flag_sel ^ bus.CondInv;
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    branch  = 1'b0;
    pcsrc   = 1'b0;
    ritype  = 1'b0;
    halt    = 1'b1;

    case (state_q)
      RUN: begin
        halt = 1'b0;
        if (bus.IsHalt) begin
          halt    = 1'b1;
          state_d = HALTED;
          done_d  = 1'b1;
        end else if (bus.IsJump) begin
          branch = 1'b1;
          pcsrc  = cond;
        end else if (bus.IsBranch) begin
          branch = 1'b1;
          ritype = 1'b1;
          pcsrc  = cond;
        end
        if (bus.FlagWe)
          flags_d = '{z: bus.ZeroIn, c: bus.CarryIn, n: bus.NegIn};
        if (branch && pcsrc && (cnt_q != {CNT_W{1'b1}}))
          cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase

    // Init restarts from any state and wins over whatever RUN decided above.
    if (bus.Init) begin
      state_d = RUN;
      flags_d = '0;
      done_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      flags_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Branch     = branch;
  assign bus.PCSrc      = pcsrc;
  assign bus.RItype     = ritype;
  assign bus.Halt       = halt;
  assign bus.CondTarget = bus.CondOff;
  assign bus.Done       = done_q;
  assign bus.TakenCnt   = cnt_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed instruction stream with a
// scoreboard of expected fetch commands, counter saturation and async reset.
module tb_branch_ctrl;
  import branch_pkg::*;

  localparam int W = 36;

  typedef struct packed {
    logic        init;
    logic        is_branch;
    logic        is_jump;
    logic        is_halt;
    logic [1:0]  sel;
    logic        inv;
    logic [2:0]  off;
    logic [4:0]  idx;
    logic        fwe;
    logic        z;
    logic        c;
    logic        n;
  } stim_t;

  logic CLK;
  logic reset;
  branch_ctrl_if bus ();

  branch_ctrl dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic stim_t st(input logic init, input logic br, input logic jmp,
                               input logic hlt, input logic [1:0] sel, input logic inv,
                               input logic [2:0] off, input logic [4:0] idx,
                               input logic fwe, input logic z, input logic c, input logic n);
    stim_t s;
    s = '{init, br, jmp, hlt, sel, inv, off, idx, fwe, z, c, n};
    return s;
  endfunction

  // {Branch, PCSrc, RItype, Halt, Done, TakenCnt, CondTarget, Target}
  function automatic logic [W-1:0] ev(input logic br, input logic pc, input logic ri,
                                      input logic hl, input logic dn, input logic [15:0] cnt,
                                      input logic [2:0] ct, input logic [11:0] tgt);
    return {br, pc, ri, hl, dn, cnt, ct, tgt};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.Branch, bus.PCSrc, bus.RItype, bus.Halt, bus.Done,
            bus.TakenCnt, bus.CondTarget, bus.Target};
  endfunction

  task automatic apply(input stim_t s);
    bus.Init     = s.init;
    bus.IsBranch = s.is_branch;
    bus.IsJump   = s.is_jump;
    bus.IsHalt   = s.is_halt;
    bus.CondSel  = s.sel;
    bus.CondInv  = s.inv;
    bus.CondOff  = s.off;
    bus.LutIdx   = s.idx;
    bus.FlagWe   = s.fwe;
    bus.ZeroIn   = s.z;
    bus.CarryIn  = s.c;
    bus.NegIn    = s.n;
  endtask

  // Drive one instruction cycle and score the combinational/registered view.
  task automatic cyc(input string tag, input stim_t s, input logic [W-1:0] e);
    @(negedge CLK);
    apply(s);
    exp_q.push_back(e);
    #1;
    check(tag, observed(), exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  stim_t nop;

  initial begin
    nop = st(0,0,0,0, 2'b00,0, 3'd0, 5'd0, 0,0,0,0);
    reset = 1'b1;
    apply(nop);
    #1;
    check("reset_outputs", observed(), ev(0,0,0,1,0,16'd0,3'd0,12'h000));
    check("reset_state", W'(bus.state_dbg), W'(IDLE));
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;

    cyc("idle",       nop,                                          ev(0,0,0,1,0,16'd0,3'd0,12'h000));
    cyc("init_cycle", st(1,0,0,0, 2'b00,0, 3'd0, 5'd0, 0,0,0,0),   ev(0,0,0,1,0,16'd0,3'd0,12'h000));
    cyc("run_nop",    nop,                                          ev(0,0,0,0,0,16'd0,3'd0,12'h000));
    check("run_state", W'(bus.state_dbg), W'(RUN));
    cyc("set_z",      st(0,0,0,0, 2'b00,0, 3'd0, 5'd0, 1,1,0,0),   ev(0,0,0,0,0,16'd0,3'd0,12'h000));
    cyc("br_z_taken", st(0,1,0,0, 2'b01,0, 3'd3, 5'd0, 0,0,0,0),   ev(1,1,1,0,0,16'd0,3'd3,12'h000));
    cyc("br_z_inv",   st(0,1,0,0, 2'b01,1, 3'd3, 5'd0, 0,0,0,0),   ev(1,0,1,0,0,16'd1,3'd3,12'h000));
    cyc("clear_z",    st(0,0,0,0, 2'b00,0, 3'd0, 5'd0, 1,0,0,0),   ev(0,0,0,0,0,16'd1,3'd0,12'h000));
    cyc("same_cyc_flag", st(0,1,0,0, 2'b01,0, 3'd1, 5'd0, 1,1,0,0), ev(1,0,1,0,0,16'd1,3'd1,12'h000));
    cyc("flag_next",  st(0,1,0,0, 2'b01,0, 3'd1, 5'd0, 0,0,0,0),   ev(1,1,1,0,0,16'd1,3'd1,12'h000));
    cyc("set_c",      st(0,0,0,0, 2'b00,0, 3'd0, 5'd0, 1,0,1,0),   ev(0,0,0,0,0,16'd2,3'd0,12'h000));
    cyc("br_c_taken", st(0,1,0,0, 2'b10,0, 3'd7, 5'd0, 0,0,0,0),   ev(1,1,1,0,0,16'd2,3'd7,12'h000));
    cyc("br_n_clear", st(0,1,0,0, 2'b11,0, 3'd0, 5'd0, 0,0,0,0),   ev(1,0,1,0,0,16'd3,3'd0,12'h000));
    cyc("br_spin",    st(0,1,0,0, 2'b11,1, 3'd0, 5'd0, 0,0,0,0),   ev(1,1,1,0,0,16'd3,3'd0,12'h000));
    cyc("jump_lut5",  st(0,0,1,0, 2'b00,0, 3'd0, 5'd5, 0,0,0,0),   ev(1,1,0,0,0,16'd4,3'd0,12'h02A));
    cyc("jump_prio",  st(0,1,1,0, 2'b00,1, 3'd2, 5'd31, 0,0,0,0),  ev(1,0,0,0,0,16'd5,3'd2,12'h1F0));
    cyc("halt_prio",  st(0,1,1,1, 2'b00,0, 3'd0, 5'd0, 0,0,0,0),   ev(0,0,0,1,0,16'd5,3'd0,12'h000));
    for (int i = 0; i < 10; i++)
      cyc("halted_hold", st(0,1,0,0, 2'b00,0, 3'd0, 5'd0, 0,0,0,0), ev(0,0,0,1,1,16'd5,3'd0,12'h000));
    check("halted_state", W'(bus.state_dbg), W'(HALTED));
    cyc("init_halted", st(1,0,0,0, 2'b00,0, 3'd0, 5'd0, 0,0,0,0),  ev(0,0,0,1,1,16'd5,3'd0,12'h000));
    cyc("after_init", nop,                                          ev(0,0,0,0,0,16'd0,3'd0,12'h000));
    cyc("flags_cleared", st(0,1,0,0, 2'b10,0, 3'd4, 5'd0, 0,0,0,0), ev(1,0,1,0,0,16'd0,3'd4,12'h000));

    @(negedge CLK);
    apply(st(0,1,0,0, 2'b00,0, 3'd0, 5'd0, 0,0,0,0));
    repeat (65540) @(posedge CLK);
    cyc("cnt_saturate", st(0,1,0,0, 2'b00,0, 3'd0, 5'd0, 0,0,0,0), ev(1,1,1,0,0,16'hFFFF,3'd0,12'h000));
    cyc("cnt_hold",     st(0,1,0,0, 2'b00,0, 3'd0, 5'd0, 0,0,0,0), ev(1,1,1,0,0,16'hFFFF,3'd0,12'h000));

    @(negedge CLK);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", observed(), ev(0,0,0,1,0,16'd0,3'd0,12'h000));
    check("async_reset_state", W'(bus.state_dbg), W'(IDLE));
    @(negedge CLK);
    reset = 1'b0;
    apply(nop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
